drum_cycle_timer: RTL and testbench
===================================

Name: drum_cycle_timer

Overview:
- Measures the clock-cycle latency of one drum-solver iteration, from the solver's start strobe to its done strobe.
- Publishes the latched result as a stable 32-bit word that feeds the HPS-readable counter input PIO (in_port), plus status and a completed-measurement count.
- Sequences the measurement with a 3-state FSM, so the HPS never reads a partially-updated count.

Parameters:
- CNT_W, 32: width of the running counter and of result.
- SCNT_W, 16: width of the completed-measurement counter sample_cnt.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle strobe; solver begins an iteration.
- done  in  1  single-cycle strobe; solver finished the iteration.
- clear  in  1  synchronous clear from the HPS control PIO; level-sampled every cycle.
- result  out  CNT_W  latched latency of the last completed measurement; drives the counter PIO in_port.
- result_valid  out  1  result holds at least one completed measurement since reset/clear.
- running  out  1  FSM is in RUN.
- overflow  out  1  sticky: the counter saturated during some measurement.
- overrun  out  1  sticky: start arrived while in RUN without a coincident done.
- sample_cnt  out  SCNT_W  number of completed measurements; wraps.
- max_result  out  CNT_W  see Optional Feature.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All outputs and internal registers go to 0; the FSM goes to IDLE.
- FSM states:
  - IDLE: result_valid=0.
  - RUN: running=1.
  - DONE: result_valid=1, result held.
- Transitions:
  - IDLE or DONE, start=1 -> RUN; cnt<=0.
  - RUN, done=1, start=0 -> DONE; result<=sat(cnt+1); sample_cnt<=sample_cnt+1.
  - RUN, done=1, start=1 -> stay in RUN; result latched and sample_cnt incremented as above; cnt<=0 (back-to-back iterations). overrun is not set.
  - RUN, start=1, done=0 -> stay in RUN; cnt<=0 (measurement restarted); overrun<=1.
  - RUN, neither strobe -> cnt<=sat(cnt+1).
  - done in IDLE or DONE: ignored, no state change.
- Latency definition: start sampled at edge k and done sampled at edge k+N gives result=N. The minimum is N=1 (done on the cycle after start).
- Saturation:
  - cnt stops at 2^CNT_W-1 and overflow<=1.
  - A result computed from a saturated cnt is 2^CNT_W-1, not a wrapped value.
- sample_cnt wraps modulo 2^SCNT_W with no flag.
- result changes only on a completing done edge, so the value is stable between completions.
- clear=1:
  - Next edge: state->IDLE; cnt, result, sample_cnt, overflow, overrun and max_result all go to 0.
  - clear has priority over start and done in the same cycle.
  - Applies from any state; a clear in mid-RUN abandons the measurement.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-RUN: immediate return to reset values; the measurement is lost.

Optional Feature:
- Macro DRUM_TIMER_MAX_TRACK_EN.
- Defined: max_result is a register. On every completion, max_result<=max(max_result, new result), updated on the same edge as result. It is cleared by reset and by clear.
- Undefined: max_result is tied to constant 0 and no comparator is built.

Test Plan:
- Reset, then start at cycle 10 and done at cycle 110 -> result=100, result_valid=1, sample_cnt=1, running=0 from cycle 111.
- start and done both high in RUN at cycle 50 (start was at cycle 20) -> result=30, FSM stays in RUN; done 7 cycles later -> result=7, sample_cnt=2, overrun=0.
- Second start at cycle 40 after start at cycle 20, then done at cycle 45 -> overrun=1, result=5.
- Force CNT_W=8; start, then done 300 cycles later -> result=255, overflow=1; a subsequent 10-cycle measurement -> result=10, overflow still 1.
- clear asserted in the same cycle as done during RUN -> result=0, sample_cnt=0, FSM in IDLE, flags 0; a done in IDLE -> no change.
- With DRUM_TIMER_MAX_TRACK_EN: measurements of 40, 90, 60 cycles -> max_result=90. Without the macro -> max_result=0 throughout.

Source files
------------

// File: rtl/drum_cycle_timer_if.sv
// Solver strobes, HPS clear and the published timer results, grouped as one bundle.
interface drum_cycle_timer_if #(
  parameter int CNT_W  = 32,
  parameter int SCNT_W = 16
);
  logic              start;
  logic              done;
  logic              clear;
  logic [CNT_W-1:0]  result;
  logic              result_valid;
  logic              running;
  logic              overflow;
  logic              overrun;
  logic [SCNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0]  max_result;

  modport master (
    output start, done, clear,
    input  result, result_valid, running, overflow, overrun, sample_cnt, max_result
  );

  modport slave (
    input  start, done, clear,
    output result, result_valid, running, overflow, overrun, sample_cnt, max_result
  );
endinterface

// File: rtl/drum_cycle_timer.sv
// Cycle latency of one drum-solver iteration (start strobe to done strobe), published for the HPS.
// Optional max-latency tracking is built only when DRUM_TIMER_MAX_TRACK_EN is defined.
module drum_cycle_timer #(
  parameter int CNT_W  = 32,
  parameter int SCNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  drum_cycle_timer_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  result_q;
  logic              result_valid_q;
  logic              overflow_q;
  logic              overrun_q;
  logic [SCNT_W-1:0] sample_cnt_q;

  // Saturating increment; also the value latched on completion.
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_sat = (cnt == CNT_MAX);
  assign cnt_inc = cnt_sat ? CNT_MAX : cnt + CNT_W'(1);

  logic complete;
  assign complete = (state == RUN) && bus.done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      overrun_q      <= 1'b0;
      sample_cnt_q   <= '0;
    end else if (bus.clear) begin
      state          <= IDLE;
      cnt            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      overrun_q      <= 1'b0;
      sample_cnt_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (bus.done) begin
            result_q       <= cnt_inc;
            result_valid_q <= 1'b1;
            sample_cnt_q   <= sample_cnt_q + SCNT_W'(1);
            if (cnt_sat) overflow_q <= 1'b1;
            // A coincident start begins the next iteration without a DONE visit.
            if (bus.start) cnt   <= '0;
            else           state <= DONE;
          end else if (bus.start) begin
            cnt       <= '0;
            overrun_q <= 1'b1;
          end else begin
            cnt <= cnt_inc;
            if (cnt_sat) overflow_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.running      = (state == RUN);
  assign bus.overflow     = overflow_q;
  assign bus.overrun      = overrun_q;
  assign bus.sample_cnt   = sample_cnt_q;

`ifdef DRUM_TIMER_MAX_TRACK_EN
  logic [CNT_W-1:0] max_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             max_q <= '0;
    else if (bus.clear)                       max_q <= '0;
    else if (complete && (cnt_inc > max_q))   max_q <= cnt_inc;
  end
  assign bus.max_result = max_q;
`else
  logic unused_complete;
  assign unused_complete = complete;
  assign bus.max_result  = '0;
`endif
endmodule

// File: tb/tb_drum_cycle_timer.sv
// Scoreboard bench: stimulus pushes expected completions, monitors pop on every sample_cnt change.
module tb_drum_cycle_timer;
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  drum_cycle_timer_if #(.CNT_W(32), .SCNT_W(16)) a ();
  drum_cycle_timer_if #(.CNT_W(8),  .SCNT_W(16)) b ();

  drum_cycle_timer #(.CNT_W(32), .SCNT_W(16)) dut32 (.clk(clk), .reset_n(reset_n), .bus(a));
  drum_cycle_timer #(.CNT_W(8),  .SCNT_W(16)) dut8  (.clk(clk), .reset_n(reset_n), .bus(b));

`ifdef DRUM_TIMER_MAX_TRACK_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic [15:0] scnt;
    logic        vld;
    logic        ovf;
    logic        ovr;
    logic [31:0] mx;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  int checks = 0;
  int errors = 0;

  // Reference state per DUT: index 0 = 32-bit, 1 = 8-bit.
  int          use8 = 0;
  logic [15:0] m_scnt [2];
  logic [31:0] m_max  [2];
  logic        m_ovf  [2];
  logic        m_ovr  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic d, input logic c);
    if (use8 != 0) begin
      b.start = s; b.done = d; b.clear = c;
      a.start = 1'b0; a.done = 1'b0; a.clear = 1'b0;
    end else begin
      a.start = s; a.done = d; a.clear = c;
      b.start = 1'b0; b.done = 1'b0; b.clear = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input exp_t e);
    if (use8 != 0) q8.push_back(e);
    else           q32.push_back(e);
  endtask

  task automatic expect_done(input logic [31:0] r);
    exp_t e;
    m_scnt[use8] = m_scnt[use8] + 16'd1;
    if (r > m_max[use8]) m_max[use8] = r;
    e.res  = r;
    e.scnt = m_scnt[use8];
    e.vld  = 1'b1;
    e.ovf  = m_ovf[use8];
    e.ovr  = m_ovr[use8];
    e.mx   = MAXEN ? m_max[use8] : 32'd0;
    push(e);
  endtask

  task automatic expect_zero();
    exp_t e;
    if (m_scnt[use8] != 16'd0) begin
      e.res = '0; e.scnt = '0; e.vld = 1'b0; e.ovf = 1'b0; e.ovr = 1'b0; e.mx = '0;
      push(e);
    end
    m_scnt[use8] = '0; m_max[use8] = '0; m_ovf[use8] = 1'b0; m_ovr[use8] = 1'b0;
  endtask

  // start sampled at edge k, done sampled at edge k+n
  task automatic measure(input int n);
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    if (n > 1) cyc(n - 1);
    drive(1'b0, 1'b1, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] prev32 = '0;
  logic [15:0] prev8  = '0;

  always @(negedge clk) begin
    if (a.sample_cnt !== prev32) begin
      prev32 = a.sample_cnt;
      if (q32.size() == 0) begin
        chk("dut32 unexpected completion, sample_cnt", {16'd0, a.sample_cnt}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("dut32 result",       a.result,                e.res);
        chk("dut32 sample_cnt",   {16'd0, a.sample_cnt},   {16'd0, e.scnt});
        chk("dut32 result_valid", {31'd0, a.result_valid}, {31'd0, e.vld});
        chk("dut32 overflow",     {31'd0, a.overflow},     {31'd0, e.ovf});
        chk("dut32 overrun",      {31'd0, a.overrun},      {31'd0, e.ovr});
        chk("dut32 max_result",   a.max_result,            e.mx);
      end
    end
  end

  always @(negedge clk) begin
    if (b.sample_cnt !== prev8) begin
      prev8 = b.sample_cnt;
      if (q8.size() == 0) begin
        chk("dut8 unexpected completion, sample_cnt", {16'd0, b.sample_cnt}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("dut8 result",       {24'd0, b.result},      e.res);
        chk("dut8 sample_cnt",   {16'd0, b.sample_cnt},  {16'd0, e.scnt});
        chk("dut8 result_valid", {31'd0, b.result_valid}, {31'd0, e.vld});
        chk("dut8 overflow",     {31'd0, b.overflow},    {31'd0, e.ovf});
        chk("dut8 overrun",      {31'd0, b.overrun},     {31'd0, e.ovr});
        chk("dut8 max_result",   {24'd0, b.max_result},  e.mx);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_scnt[i] = '0; m_max[i] = '0; m_ovf[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset result",       a.result,                 32'd0);
    chk("reset result_valid", {31'd0, a.result_valid},  32'd0);
    chk("reset running",      {31'd0, a.running},       32'd0);
    chk("reset overflow",     {31'd0, a.overflow},      32'd0);
    chk("reset overrun",      {31'd0, a.overrun},       32'd0);
    chk("reset sample_cnt",   {16'd0, a.sample_cnt},    32'd0);
    chk("reset max_result",   a.max_result,             32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(5);

    // 100-cycle measurement
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    cyc(50);
    chk("running mid-measurement", {31'd0, a.running}, 32'd1);
    cyc(49);
    drive(1'b0, 1'b1, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    expect_done(32'd100);
    chk("running after done",     {31'd0, a.running},      32'd0);
    chk("result_valid after done", {31'd0, a.result_valid}, 32'd1);
    cyc(3);

    // back-to-back: done+start at 30, then done 7 later
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    cyc(29);
    drive(1'b1, 1'b1, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    expect_done(32'd30);
    chk("running after back-to-back", {31'd0, a.running}, 32'd1);
    cyc(6);
    drive(1'b0, 1'b1, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    expect_done(32'd7);
    cyc(3);

    // restart at +20, done at +25 -> overrun, result 5
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    cyc(19);
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    cyc(4);
    drive(1'b0, 1'b1, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    m_ovr[0] = 1'b1;
    expect_done(32'd5);
    cyc(3);

    // clear coincident with done wins; done in IDLE is ignored
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    cyc(10);
    drive(1'b0, 1'b1, 1'b1);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    expect_zero();
    chk("running after clear",      {31'd0, a.running},      32'd0);
    chk("result_valid after clear", {31'd0, a.result_valid}, 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    cyc(2);
    chk("idle done result",     a.result,              32'd0);
    chk("idle done sample_cnt", {16'd0, a.sample_cnt}, 32'd0);
    chk("idle done running",    {31'd0, a.running},    32'd0);

    // max tracking over 40, 90, 60
    measure(40); expect_done(32'd40); cyc(2);
    measure(90); expect_done(32'd90); cyc(2);
    measure(60); expect_done(32'd60); cyc(2);
    chk("max_result after 40/90/60", a.max_result, MAXEN ? 32'd90 : 32'd0);

    // reset mid-measurement
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0);
    cyc(5);
    expect_zero();
    reset_n = 1'b0;
    #2;
    chk("async reset running", {31'd0, a.running},    32'd0);
    chk("async reset result",  a.result,              32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(3);

    // 8-bit counter saturation
    use8 = 1;
    measure(300);
    m_ovf[1] = 1'b1;
    expect_done(32'd255);
    cyc(3);
    measure(10);
    expect_done(32'd10);
    cyc(4);

    chk("dut32 scoreboard drained", q32.size(), 32'd0);
    chk("dut8 scoreboard drained",  q8.size(),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
